fetch_ctrl: RTL and testbench

FETCH_CTRL -- requirements
Module: fetch_ctrl

---
 rtl/fetch_ctrl.sv | 154 +++++++++++++++
 tb/tb_fetch_ctrl.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_ctrl.sv
// Instruction fetch/decode sequencer: fetches 16-bit words from the instruction ROM,
// decodes HALT/JMP/ALU opcodes and drives the PC control pair {PC_load,PC_inc}.
module fetch_ctrl (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [15:0] ins_data,
   input  logic        rom_valid,
   input  logic        stall,
   input  logic        exec_done,
   output logic        PC_load,
   output logic        PC_inc,
   output logic [15:0] Ins_addr,
   output logic        rom_req,
   output logic [15:0] ir,
   output logic        ir_valid,
   output logic        exec_start,
   output logic        halted,
   output logic [15:0] instr_count
);

   typedef enum logic [2:0] {
      S_CLR,
      S_FETCH,
      S_DECODE,
      S_EXEC,
      S_SETTLE,
      S_HALT
   } state_e;

   // PC control pair, ordered {PC_load, PC_inc}
   typedef enum logic [1:0] {
      PC_CLEAR = 2'b00,
      PC_INCR  = 2'b01,
      PC_LOAD  = 2'b10,
      PC_HOLD  = 2'b11
   } pc_ctl_e;

   localparam logic [3:0] OP_HALT = 4'hF;
   localparam logic [3:0] OP_JMP  = 4'hE;

   state_e      state_q, state_d;
   logic        settle_q, settle_d;
   logic        exec_first_q, exec_first_d;
   logic [15:0] ir_q, ir_d;
   logic [15:0] count_q, count_d;

   pc_ctl_e     pc_ctl;
   logic        fetch_req;
   logic [3:0]  opcode;

   assign opcode    = ir_q[15:12];
   assign fetch_req = (state_q == S_FETCH) && !stall;

   // NOTE: state registers use non-blocking assignments so every register samples
   // the pre-edge values of the others; blocking here would create order-dependent races.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q      <= S_CLR;
         settle_q     <= 1'b0;
         exec_first_q <= 1'b0;
         ir_q         <= 16'h0000;
         count_q      <= 16'h0000;
      end else begin
         state_q      <= state_d;
         settle_q     <= settle_d;
         exec_first_q <= exec_first_d;
         ir_q         <= ir_d;
         count_q      <= count_d;
      end
   end

   // NOTE: every signal written here gets a default first, so no path leaves one
   // unassigned and no latch is inferred.
   always_comb begin
      state_d      = state_q;
      settle_d     = settle_q;
      exec_first_d = 1'b0;
      ir_d         = ir_q;
      count_d      = count_q;

      case (state_q)
         S_CLR: begin
            settle_d = 1'b0;
            state_d  = S_SETTLE;
         end
         S_FETCH: begin
            // A word offered while stalled is not captured; it must be re-offered.
            if (rom_valid && fetch_req) begin
               ir_d    = ins_data;
               state_d = S_DECODE;
            end
         end
         S_DECODE: begin
            count_d = count_q + 16'd1;
            case (opcode)
               OP_HALT: state_d = S_HALT;
               OP_JMP: begin
                  settle_d = 1'b0;
                  state_d  = S_SETTLE;
               end
               default: begin
                  exec_first_d = 1'b1;
                  state_d      = S_EXEC;
               end
            endcase
         end
         S_EXEC: begin
            if (exec_done) begin
               settle_d = 1'b0;
               state_d  = S_SETTLE;
            end
         end
         S_SETTLE: begin
            // Two hold cycles cover the PC update-to-output latency.
            if (settle_q) begin
               settle_d = 1'b0;
               state_d  = S_FETCH;
            end else begin
               settle_d = 1'b1;
            end
         end
         S_HALT:  state_d = S_HALT;
         default: state_d = S_CLR;
      endcase
   end

   always_comb begin
      pc_ctl   = PC_HOLD;
      ir_valid = 1'b0;
      halted   = 1'b0;

      case (state_q)
         S_CLR: pc_ctl = PC_CLEAR;
         S_DECODE: begin
            ir_valid = 1'b1;
            case (opcode)
               OP_HALT: pc_ctl = PC_HOLD;
               OP_JMP:  pc_ctl = PC_LOAD;
               default: pc_ctl = PC_INCR;
            endcase
         end
         S_HALT:  halted = 1'b1;
         default: pc_ctl = PC_HOLD;
      endcase
   end

   assign {PC_load, PC_inc} = pc_ctl;
   assign rom_req           = fetch_req;
   assign exec_start        = (state_q == S_EXEC) && exec_first_q;
   assign Ins_addr          = {4'h0, ir_q[11:0]};
   assign ir                = ir_q;
   assign instr_count       = count_q;

endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed bench for fetch_ctrl: decode and exec-start events are scored against
// queued expectations by a monitor; cycle-level sequencing is checked inline.
module tb_fetch_ctrl;

   logic        clk;
   logic        rst_n;
   logic [15:0] ins_data;
   logic        rom_valid;
   logic        stall;
   logic        exec_done;
   logic        PC_load;
   logic        PC_inc;
   logic [15:0] Ins_addr;
   logic        rom_req;
   logic [15:0] ir;
   logic        ir_valid;
   logic        exec_start;
   logic        halted;
   logic [15:0] instr_count;

   fetch_ctrl dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .ins_data    (ins_data),
      .rom_valid   (rom_valid),
      .stall       (stall),
      .exec_done   (exec_done),
      .PC_load     (PC_load),
      .PC_inc      (PC_inc),
      .Ins_addr    (Ins_addr),
      .rom_req     (rom_req),
      .ir          (ir),
      .ir_valid    (ir_valid),
      .exec_start  (exec_start),
      .halted      (halted),
      .instr_count (instr_count)
   );

   typedef struct {
      logic [15:0] ir;
      logic [1:0]  pc;
      logic [15:0] addr;
      logic [15:0] cnt;
   } dec_t;

   dec_t        dec_q[$];
   logic [15:0] exec_q[$];

   int n_cmp  = 0;
   int n_fail = 0;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check_reset(input string tag);
      check({tag, "_pc"},         {30'd0, PC_load, PC_inc}, 32'd0);
      check({tag, "_rom_req"},    {31'd0, rom_req},         32'd0);
      check({tag, "_ir"},         {16'd0, ir},              32'h0000);
      check({tag, "_ir_valid"},   {31'd0, ir_valid},        32'd0);
      check({tag, "_exec_start"}, {31'd0, exec_start},      32'd0);
      check({tag, "_halted"},     {31'd0, halted},          32'd0);
      check({tag, "_count"},      {16'd0, instr_count},     32'h0000);
   endtask

   task automatic push_dec(input logic [15:0] w, input logic [1:0] pc, input logic [15:0] cnt);
      dec_t e;
      e.ir   = w;
      e.pc   = pc;
      e.addr = {4'h0, w[11:0]};
      e.cnt  = cnt;
      dec_q.push_back(e);
   endtask

   // Monitor: the decode count is visible the cycle after ir_valid.
   logic        cnt_pending = 1'b0;
   logic [15:0] cnt_exp     = 16'h0000;

   always @(negedge clk) begin
      dec_t        e;
      logic [15:0] x;
      if (cnt_pending) begin
         check("dec_count", {16'd0, instr_count}, {16'd0, cnt_exp});
         cnt_pending = 1'b0;
      end
      if (ir_valid) begin
         if (dec_q.size() == 0) begin
            n_cmp++;
            n_fail++;
            $display("FAIL dec_unexpected: got ir=%h, expected no decode", ir);
         end else begin
            e = dec_q.pop_front();
            check("dec_ir",   {16'd0, ir},               {16'd0, e.ir});
            check("dec_pc",   {30'd0, PC_load, PC_inc},  {30'd0, e.pc});
            check("dec_addr", {16'd0, Ins_addr},         {16'd0, e.addr});
            cnt_pending = 1'b1;
            cnt_exp     = e.cnt;
         end
      end
      if (exec_start) begin
         if (exec_q.size() == 0) begin
            n_cmp++;
            n_fail++;
            $display("FAIL exec_unexpected: got exec_start with ir=%h, expected none", ir);
         end else begin
            x = exec_q.pop_front();
            check("exec_ir", {16'd0, ir}, {16'd0, x});
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout, expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      rst_n     = 1'b0;
      ins_data  = 16'h0000;
      rom_valid = 1'b0;
      stall     = 1'b0;
      exec_done = 1'b0;

      // Reset and release
      repeat (3) tick();
      check_reset("rst_hold");
      rst_n = 1'b1;
      #1;
      check("rel_clr_pc", {30'd0, PC_load, PC_inc}, 32'd0);
      tick();
      check("rel_settle0_pc", {30'd0, PC_load, PC_inc}, 32'd3);
      check("rel_settle0_req", {31'd0, rom_req}, 32'd0);
      tick();
      check("rel_settle1_pc", {30'd0, PC_load, PC_inc}, 32'd3);
      check("rel_settle1_req", {31'd0, rom_req}, 32'd0);
      tick();
      check("rel_fetch_req", {31'd0, rom_req}, 32'd1);
      check("rel_fetch_pc", {30'd0, PC_load, PC_inc}, 32'd3);

      // ALU instruction, exec_done on the third EXEC cycle
      ins_data  = 16'h1234;
      rom_valid = 1'b1;
      push_dec(16'h1234, 2'b01, 16'h0001);
      exec_q.push_back(16'h1234);
      tick();
      rom_valid = 1'b0;
      check("alu_decode_valid", {31'd0, ir_valid}, 32'd1);
      tick();
      check("alu_exec_start", {31'd0, exec_start}, 32'd1);
      tick();
      check("alu_exec_start_once", {31'd0, exec_start}, 32'd0);
      tick();
      exec_done = 1'b1;
      tick();
      exec_done = 1'b0;
      check("alu_settle0_pc", {30'd0, PC_load, PC_inc}, 32'd3);
      check("alu_settle0_req", {31'd0, rom_req}, 32'd0);
      tick();
      check("alu_settle1_req", {31'd0, rom_req}, 32'd0);
      tick();
      check("alu_fetch_req", {31'd0, rom_req}, 32'd1);

      // Jump: no EXEC, straight to SETTLE
      ins_data  = 16'hE0A5;
      rom_valid = 1'b1;
      push_dec(16'hE0A5, 2'b10, 16'h0002);
      tick();
      rom_valid = 1'b0;
      check("jmp_addr", {16'd0, Ins_addr}, 32'h000000A5);
      tick();
      check("jmp_settle_pc", {30'd0, PC_load, PC_inc}, 32'd3);
      tick();
      tick();
      check("jmp_fetch_req", {31'd0, rom_req}, 32'd1);

      // Stall blocks capture; released stall captures the word
      stall     = 1'b1;
      ins_data  = 16'h2222;
      rom_valid = 1'b1;
      #1;
      check("stall_req", {31'd0, rom_req}, 32'd0);
      tick();
      check("stall_ir_hold", {16'd0, ir}, 32'h0000E0A5);
      check("stall_no_decode", {31'd0, ir_valid}, 32'd0);
      tick();
      check("stall_req_2", {31'd0, rom_req}, 32'd0);
      check("stall_pc", {30'd0, PC_load, PC_inc}, 32'd3);
      stall = 1'b0;
      push_dec(16'h2222, 2'b01, 16'h0003);
      exec_q.push_back(16'h2222);
      #1;
      check("unstall_req", {31'd0, rom_req}, 32'd1);
      tick();
      rom_valid = 1'b0;
      tick();
      exec_done = 1'b1;
      tick();
      exec_done = 1'b0;
      check("exec_min_settle_req", {31'd0, rom_req}, 32'd0);
      tick();
      tick();
      check("stall_fetch_req", {31'd0, rom_req}, 32'd1);

      // Counter wrap, then reset in the middle of EXEC
      force dut.count_q = 16'hFFFF;
      #1;
      release dut.count_q;
      ins_data  = 16'h3333;
      rom_valid = 1'b1;
      push_dec(16'h3333, 2'b01, 16'h0000);
      exec_q.push_back(16'h3333);
      tick();
      rom_valid = 1'b0;
      tick();
      tick();
      rst_n = 1'b0;
      tick();
      check_reset("rst_exec");
      rst_n = 1'b1;
      tick();
      tick();
      tick();
      check("rst2_fetch_req", {31'd0, rom_req}, 32'd1);

      // HALT: inputs ignored, only reset exits
      ins_data  = 16'hF000;
      rom_valid = 1'b1;
      push_dec(16'hF000, 2'b11, 16'h0001);
      tick();
      exec_done = 1'b1;
      ins_data  = 16'h5555;
      for (int i = 0; i < 5; i++) begin
         tick();
         check("halt_halted", {31'd0, halted}, 32'd1);
         check("halt_pc", {30'd0, PC_load, PC_inc}, 32'd3);
         check("halt_req", {31'd0, rom_req}, 32'd0);
         check("halt_ir", {16'd0, ir}, 32'h0000F000);
      end
      rom_valid = 1'b0;
      exec_done = 1'b0;
      rst_n     = 1'b0;
      tick();
      check_reset("rst_halt");
      rst_n = 1'b1;
      tick();

      check("dec_queue_drained", dec_q.size(), 32'd0);
      check("exec_queue_drained", exec_q.size(), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
